// File: rtl/bidir_ring_counter.sv
// Bidirectional ring counter for the active-low LED bank.
// Two active-low push buttons are synchronized and debounced; a debounced
// left press rotates the single lit LED toward the MSB, a right press
// toward the LSB. Also provides the binary LED position and a wrap pulse.
module bidir_ring_counter #(
    parameter int               BITS        = 4,
    parameter int               POS_W       = 2,
    parameter int               CNT_W       = 25,
    parameter logic [CNT_W-1:0] PULSE_METER = 25'd2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_left,
    input  logic             button_right,
    output logic [BITS-1:0]  LEDS,
    output logic [POS_W-1:0] POS,
    output logic             WRAP
);

    // Button index 0 is the left button, index 1 the right button.
    localparam int NBTN = 2;

    localparam logic [BITS-1:0]  RING_INIT = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    // Counter value at which the current sample is the PULSE_METER-th one.
    localparam logic [CNT_W-1:0] CNT_LAST  = PULSE_METER - CNT_ONE;

    // ARMED waits for a stable press, HELD waits for a stable release.
    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } deb_state_t;

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [BITS-1:0] v);
        return (v != {BITS{1'b0}}) && ((v & (v - RING_INIT)) == {BITS{1'b0}});
    endfunction

    // Binary index of the highest set bit (the only one when one-hot).
    function automatic logic [POS_W-1:0] encode_pos(input logic [BITS-1:0] v);
        logic [POS_W-1:0] idx;
        idx = {POS_W{1'b0}};
        for (int i = 0; i < BITS; i++) begin
            if (v[i]) begin
                idx = POS_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NBTN-1:0]  raw_s;
    logic [NBTN-1:0]  sync1_r;
    logic [NBTN-1:0]  sync2_r;
    deb_state_t       state_r [NBTN];
    logic [CNT_W-1:0] cnt_r   [NBTN];
    logic [NBTN-1:0]  count_en_s;
    logic [NBTN-1:0]  step_s;

    logic [BITS-1:0]  ring_r;
    logic [BITS-1:0]  ring_next_s;
    logic [POS_W-1:0] pos_r;
    logic [POS_W-1:0] pos_next_s;
    logic             wrap_r;
    logic             wrap_next_s;

    assign raw_s = {button_right, button_left};

    // Two-flop synchronizers; reset to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= {NBTN{1'b1}};
            sync2_r <= {NBTN{1'b1}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button: which level counts toward a transition, and the press step.
    always_comb begin
        count_en_s = {NBTN{1'b0}};
        step_s     = {NBTN{1'b0}};
        for (int i = 0; i < NBTN; i++) begin
            if (state_r[i] == ARMED) begin
                count_en_s[i] = ~sync2_r[i];
                step_s[i]     = ~sync2_r[i] & (cnt_r[i] == CNT_LAST);
            end else begin
                count_en_s[i] = sync2_r[i];
                step_s[i]     = 1'b0;
            end
        end
    end

    // Debouncer state and stable-sample counters; any opposite sample restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBTN; i++) begin
                state_r[i] <= HELD;
                cnt_r[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (!count_en_s[i]) begin
                    cnt_r[i]   <= CNT_ZERO;
                    state_r[i] <= state_r[i];
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]   <= CNT_ZERO;
                    state_r[i] <= (state_r[i] == ARMED) ? HELD : ARMED;
                end else begin
                    cnt_r[i]   <= cnt_r[i] + CNT_ONE;
                    state_r[i] <= state_r[i];
                end
            end
        end
    end

    // Next ring value: integrity recovery first, then single-direction steps.
    always_comb begin
        ring_next_s = ring_r;
        wrap_next_s = 1'b0;
        if (!is_onehot(ring_r)) begin
            ring_next_s = RING_INIT;
            wrap_next_s = 1'b0;
        end else if (step_s[0] && !step_s[1]) begin
            ring_next_s = {ring_r[BITS-2:0], ring_r[BITS-1]};
            wrap_next_s = ring_r[BITS-1];
        end else if (step_s[1] && !step_s[0]) begin
            ring_next_s = {ring_r[0], ring_r[BITS-1:1]};
            wrap_next_s = ring_r[0];
        end else begin
            ring_next_s = ring_r;
            wrap_next_s = 1'b0;
        end
        pos_next_s = encode_pos(ring_next_s);
    end

    // Ring, position and wrap registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_r <= RING_INIT;
            pos_r  <= {POS_W{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            ring_r <= ring_next_s;
            pos_r  <= pos_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign LEDS = ~ring_r;
    assign POS  = pos_r;
    assign WRAP = wrap_r;

endmodule

// File: tb/tb_bidir_ring_counter.sv
// Directed testbench for bidir_ring_counter with PULSE_METER=4, BITS=4.
module tb_bidir_ring_counter;

    logic       clk;
    logic       reset;
    logic       button_left;
    logic       button_right;
    logic [3:0] LEDS;
    logic [1:0] POS;
    logic       WRAP;

    int checks;
    int errors;
    int chg_cnt;
    int wrap_cnt;
    logic [3:0] prev_leds;

    bidir_ring_counter #(
        .BITS(4),
        .POS_W(2),
        .CNT_W(25),
        .PULSE_METER(25'd4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_left(button_left),
        .button_right(button_right),
        .LEDS(LEDS),
        .POS(POS),
        .WRAP(WRAP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count LED changes and WRAP-high cycles, sampled on the falling edge.
    initial begin
        chg_cnt   = 0;
        wrap_cnt  = 0;
        prev_leds = 4'b1110;
    end
    always @(negedge clk) begin
        if (LEDS !== prev_leds) chg_cnt++;
        prev_leds = LEDS;
        if (WRAP === 1'b1) wrap_cnt++;
    end

    typedef struct {
        logic       press_l;
        logic       press_r;
        int         hold;
        logic [3:0] leds;
        logic [1:0] pos;
        int         wraps;
        int         chgs;
    } vec_t;

    vec_t vecs [10];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int c0;
        int w0;
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 1'b0, 20, 4'b1101, 2'd1, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 20, 4'b1011, 2'd2, 0, 1};
        vecs[2] = '{1'b1, 1'b0, 20, 4'b0111, 2'd3, 0, 1};
        vecs[3] = '{1'b1, 1'b0, 20, 4'b1110, 2'd0, 1, 1};
        vecs[4] = '{1'b0, 1'b1, 20, 4'b0111, 2'd3, 1, 1};
        vecs[5] = '{1'b0, 1'b1,  8, 4'b1011, 2'd2, 0, 1};
        vecs[6] = '{1'b1, 1'b1, 20, 4'b1011, 2'd2, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 20, 4'b0111, 2'd3, 0, 1};
        vecs[8] = '{1'b0, 1'b1,  3, 4'b0111, 2'd3, 0, 0};
        vecs[9] = '{1'b1, 1'b0,  4, 4'b1110, 2'd0, 1, 1};

        // Reset, then release with buttons idle.
        reset        = 1'b0;
        button_left  = 1'b1;
        button_right = 1'b1;
        tick(3);
        chk("rst_leds", 32'(LEDS), 32'(4'b1110));
        chk("rst_pos",  32'(POS),  32'(2'd0));
        chk("rst_wrap", 32'(WRAP), 32'(1'b0));
        reset = 1'b1;
        c0 = chg_cnt;
        w0 = wrap_cnt;
        tick(10);
        chk("arm_leds", 32'(LEDS), 32'(4'b1110));
        chk("arm_pos",  32'(POS),  32'(2'd0));
        chk("arm_chg",  32'(chg_cnt - c0),  32'(0));
        chk("arm_wrap", 32'(wrap_cnt - w0), 32'(0));

        // Table of presses: press, hold, release, settle, compare.
        for (int i = 0; i < 10; i++) begin
            c0 = chg_cnt;
            w0 = wrap_cnt;
            button_left  = ~vecs[i].press_l;
            button_right = ~vecs[i].press_r;
            tick(vecs[i].hold);
            button_left  = 1'b1;
            button_right = 1'b1;
            tick(12);
            chk($sformatf("vec%0d_leds", i), 32'(LEDS), 32'(vecs[i].leds));
            chk($sformatf("vec%0d_pos", i),  32'(POS),  32'(vecs[i].pos));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap_cnt - w0), 32'(vecs[i].wraps));
            chk($sformatf("vec%0d_chg", i),  32'(chg_cnt - c0),  32'(vecs[i].chgs));
        end

        // Press latency: first sampling edge e0, update exactly at e0+5.
        c0 = chg_cnt;
        button_left = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk($sformatf("lat_pre%0d", k), 32'(LEDS), 32'(4'b1110));
        end
        tick(1);
        chk("lat_leds", 32'(LEDS), 32'(4'b1101));
        chk("lat_pos",  32'(POS),  32'(2'd1));
        tick(14);
        button_left = 1'b1;
        tick(12);
        chk("lat_once", 32'(chg_cnt - c0), 32'(1));

        // Bounce: low3/high1 for 40 cycles never steps; steady low then steps once.
        c0 = chg_cnt;
        repeat (10) begin
            button_left = 1'b0;
            tick(3);
            button_left = 1'b1;
            tick(1);
        end
        chk("bnc_chg",  32'(chg_cnt - c0), 32'(0));
        chk("bnc_leds", 32'(LEDS), 32'(4'b1101));
        button_left = 1'b0;
        tick(20);
        button_left = 1'b1;
        tick(12);
        chk("bnc_step_leds", 32'(LEDS), 32'(4'b1011));
        chk("bnc_step_pos",  32'(POS),  32'(2'd2));
        chk("bnc_step_chg",  32'(chg_cnt - c0), 32'(1));

        // Right button held through a reset pulse never steps.
        button_right = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        chk("hrst_async_leds", 32'(LEDS), 32'(4'b1110));
        chk("hrst_async_pos",  32'(POS),  32'(2'd0));
        tick(2);
        reset = 1'b1;
        c0 = chg_cnt;
        w0 = wrap_cnt;
        tick(30);
        chk("hrst_leds", 32'(LEDS), 32'(4'b1110));
        chk("hrst_chg",  32'(chg_cnt - c0),  32'(0));
        chk("hrst_wrap", 32'(wrap_cnt - w0), 32'(0));
        button_right = 1'b1;
        tick(12);

        // Step to position 1, then corrupt the ring and expect recovery.
        button_left = 1'b0;
        tick(20);
        button_left = 1'b1;
        tick(12);
        chk("pre_corrupt_pos", 32'(POS), 32'(2'd1));
        force dut.ring_r = 4'b0110;
        tick(1);
        chk("corrupt_pos",  32'(POS),  32'(2'd0));
        chk("corrupt_wrap", 32'(WRAP), 32'(1'b0));
        release dut.ring_r;
        tick(1);
        chk("recover_leds", 32'(LEDS), 32'(4'b1110));
        chk("recover_pos",  32'(POS),  32'(2'd0));
        chk("recover_wrap", 32'(WRAP), 32'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
